// File: rtl/gp_regfile_pkg.sv
// Shared types for the fluxcore general-purpose register file:
// sequencer opcodes, sequencer states and a small opcode helper.
package gp_regfile_pkg;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_DEC = 2'b01,
        OP_MOV = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10
    } state_e;

    // INC and DEC walk the register pair; MOV and NOP finish in a single step.
    function automatic logic is_pair_op(input op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/gp_pair_step.sv
// One WIDTH-bit slice of a register-pair increment/decrement. The LO step
// feeds cin=1; the HI step feeds the carry/borrow latched from the LO step.
module gp_pair_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             dec,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    always_comb begin
        result = operand;
        cout   = 1'b0;
        if (dec) begin
            result = operand - WIDTH'(cin);
            cout   = cin & (operand == '0);
        end else begin
            result = operand + WIDTH'(cin);
            cout   = cin & (operand == '1);
        end
    end

endmodule

// File: rtl/gp_regfile.sv
// General-purpose register file: shared tri-state bus port, two combinational
// operand read ports, and a sequencer for pair INC/DEC and register MOV.
module gp_regfile
    import gp_regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NREGS = 8,
    localparam int unsigned SELW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic             out_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SELW-1:0]  sel_in,
    output logic [WIDTH-1:0] data_out,
    input  logic [SELW-1:0]  rd_a_sel,
    input  logic [SELW-1:0]  rd_b_sel,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    input  logic             op_start,
    input  logic [1:0]       op_code,
    input  logic [SELW-1:0]  op_dst,
    input  logic [SELW-1:0]  op_src,
    output logic             busy,
    output logic             done,
    output logic             carry_out
);

    logic [WIDTH-1:0] regs [NREGS];

    state_e           state;
    op_e              op_q;
    logic [SELW-1:0]  dst_q;
    logic [SELW-1:0]  src_q;
    logic             carry;

    logic [SELW-1:0]  pair_lo;
    logic [SELW-1:0]  pair_hi;
    logic [WIDTH-1:0] step_in;
    logic [WIDTH-1:0] step_res;
    logic             step_dec;
    logic             step_cin;
    logic             step_cout;

    assign data_out = out_en ? regs[sel_in] : 'z;
    assign rd_a     = regs[rd_a_sel];
    assign rd_b     = regs[rd_b_sel];
    assign busy     = (state != IDLE);

    // The pair base is the destination with its LSB forced low.
    assign pair_lo = dst_q & ~SELW'(1);
    assign pair_hi = dst_q | SELW'(1);

    always_comb begin
        step_in  = regs[pair_lo];
        step_cin = 1'b1;
        step_dec = (op_q == OP_DEC);
        if (state == HI) begin
            step_in  = regs[pair_hi];
            step_cin = carry;
        end
    end

    gp_pair_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .operand (step_in),
        .dec     (step_dec),
        .cin     (step_cin),
        .result  (step_res),
        .cout    (step_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            state     <= IDLE;
            op_q      <= OP_INC;
            dst_q     <= '0;
            src_q     <= '0;
            carry     <= 1'b0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A sequenced request takes priority over a bus write in the same cycle.
                    if (op_start) begin
                        op_q  <= op_e'(op_code);
                        dst_q <= op_dst;
                        src_q <= op_src;
                        state <= LO;
                    end else if (write_en) begin
                        regs[sel_in] <= data_in;
                    end
                end
                LO: begin
                    if (is_pair_op(op_q)) begin
                        regs[pair_lo] <= step_res;
                        carry         <= step_cout;
                        state         <= HI;
                    end else begin
                        if (op_q == OP_MOV) begin
                            regs[dst_q] <= regs[src_q];
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                HI: begin
                    regs[pair_hi] <= step_res;
                    carry_out     <= step_cout;
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gp_regfile.sv
// Self-checking bench for gp_regfile (WIDTH=8, NREGS=8): expected values are
// queued when stimulus is applied and popped as DUT outputs are sampled.
module tb_gp_regfile;
    import gp_regfile_pkg::*;

    logic       clk;
    logic       rst;
    logic       write_en;
    logic       out_en;
    logic [7:0] data_in;
    logic [2:0] sel_in;
    wire  [7:0] data_out;
    logic [2:0] rd_a_sel;
    logic [2:0] rd_b_sel;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic       op_start;
    logic [1:0] op_code;
    logic [2:0] op_dst;
    logic [2:0] op_src;
    logic       busy;
    logic       done;
    logic       carry_out;

    int n_cmp;
    int n_bad;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    gp_regfile #(
        .WIDTH (8),
        .NREGS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .out_en    (out_en),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .data_out  (data_out),
        .rd_a_sel  (rd_a_sel),
        .rd_b_sel  (rd_b_sel),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .op_start  (op_start),
        .op_code   (op_code),
        .op_dst    (op_dst),
        .op_src    (op_src),
        .busy      (busy),
        .done      (done),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic sb_pop(input logic [15:0] got);
        if (exp_q.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [2:0] sel, output logic [7:0] val);
        rd_b_sel = sel;
        #1;
        val = rd_b;
    endtask

    task automatic expect_reg(input string tag, input logic [2:0] sel, input logic [7:0] val);
        logic [7:0] got;
        sb_push(tag, {8'h00, val});
        rd_reg(sel, got);
        sb_pop({8'h00, got});
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] val);
        write_en = 1'b1;
        sel_in   = sel;
        data_in  = val;
        step();
        write_en = 1'b0;
    endtask

    // Issues one op, then counts cycles until done with a bounded wait.
    task automatic run_op(input string tag, input logic [1:0] code, input logic [2:0] dst,
                          input logic [2:0] src, input int exp_cycles);
        int n;
        op_code  = code;
        op_dst   = dst;
        op_src   = src;
        op_start = 1'b1;
        sb_push({tag, "_lat"}, 16'(exp_cycles));
        step();
        op_start = 1'b0;
        op_dst   = ~dst;
        op_src   = ~src;
        op_code  = ~code;
        n = 0;
        while (!done && n < 8) begin
            step();
            n++;
        end
        sb_pop(16'(n));
    endtask

    initial begin
        logic [7:0] v;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        write_en = 1'b0;
        out_en   = 1'b0;
        data_in  = '0;
        sel_in   = '0;
        rd_a_sel = '0;
        rd_b_sel = '0;
        op_start = 1'b0;
        op_code  = '0;
        op_dst   = '0;
        op_src   = '0;
        step();
        step();
        rst = 1'b0;

        sb_push("rst_busy", 16'd0);  sb_pop({15'd0, busy});
        sb_push("rst_done", 16'd0);  sb_pop({15'd0, done});
        sb_push("rst_cout", 16'd0);  sb_pop({15'd0, carry_out});
        expect_reg("rst_r5", 3'd5, 8'h00);

        // Bus write, no bypass, tri-state read
        write_en = 1'b1;
        sel_in   = 3'd3;
        data_in  = 8'hA5;
        rd_a_sel = 3'd3;
        #1;
        sb_push("no_bypass", 16'h0000);  sb_pop({8'h00, rd_a});
        step();
        write_en = 1'b0;
        sb_push("rd_a_r3", 16'h00A5);    sb_pop({8'h00, rd_a});
        out_en = 1'b1;
        #1;
        sb_push("bus_r3", 16'h00A5);     sb_pop({8'h00, data_out});
        out_en = 1'b0;
        #1;
        sb_push("bus_released", 16'd1);  sb_pop({15'd0, data_out !== 8'hA5});

        // INC pair 2/3 with per-cycle handshake checks
        wr(3'd2, 8'hFF);
        wr(3'd3, 8'h12);
        op_code  = OP_INC;
        op_dst   = 3'd3;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        op_dst   = 3'd0;
        sb_push("inc_e0_busy", 16'd1);   sb_pop({15'd0, busy});
        step();
        sb_push("inc_e1_busy", 16'd1);   sb_pop({15'd0, busy});
        sb_push("inc_e1_done", 16'd0);   sb_pop({15'd0, done});
        expect_reg("inc_e1_r2", 3'd2, 8'h00);
        expect_reg("inc_e1_r3", 3'd3, 8'h12);
        step();
        sb_push("inc_e2_busy", 16'd0);   sb_pop({15'd0, busy});
        sb_push("inc_e2_done", 16'd1);   sb_pop({15'd0, done});
        sb_push("inc_e2_cout", 16'd0);   sb_pop({15'd0, carry_out});
        expect_reg("inc_e2_r3", 3'd3, 8'h13);
        step();
        sb_push("inc_done_once", 16'd0); sb_pop({15'd0, done});

        // Full pair wrap both directions
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF);
        run_op("inc_wrap", OP_INC, 3'd4, 3'd0, 2);
        expect_reg("inc_wrap_r4", 3'd4, 8'h00);
        expect_reg("inc_wrap_r5", 3'd5, 8'h00);
        sb_push("inc_wrap_cout", 16'd1); sb_pop({15'd0, carry_out});
        run_op("dec_wrap", OP_DEC, 3'd5, 3'd0, 2);
        expect_reg("dec_wrap_r4", 3'd4, 8'hFF);
        expect_reg("dec_wrap_r5", 3'd5, 8'hFF);
        sb_push("dec_wrap_cout", 16'd1); sb_pop({15'd0, carry_out});

        // Reserved opcode writes nothing and keeps carry_out
        run_op("nop", OP_NOP, 3'd4, 3'd0, 1);
        expect_reg("nop_r4", 3'd4, 8'hFF);
        sb_push("nop_cout", 16'd1);      sb_pop({15'd0, carry_out});

        // MOV with a simultaneous write that must be dropped
        wr(3'd0, 8'h3C);
        write_en = 1'b1;
        sel_in   = 3'd1;
        data_in  = 8'h99;
        run_op("mov", OP_MOV, 3'd7, 3'd0, 1);
        write_en = 1'b0;
        expect_reg("mov_r7", 3'd7, 8'h3C);
        expect_reg("mov_r1", 3'd1, 8'h00);
        sb_push("mov_cout", 16'd1);      sb_pop({15'd0, carry_out});

        // Requests while busy are ignored
        op_code  = OP_INC;
        op_dst   = 3'd6;
        op_start = 1'b1;
        step();
        op_code  = OP_DEC;
        op_dst   = 3'd0;
        write_en = 1'b1;
        sel_in   = 3'd0;
        data_in  = 8'h55;
        step();
        step();
        op_start = 1'b0;
        write_en = 1'b0;
        sb_push("busy_ign_done", 16'd1); sb_pop({15'd0, done});
        expect_reg("busy_ign_r6", 3'd6, 8'h01);
        expect_reg("busy_ign_r7", 3'd7, 8'h3C);
        expect_reg("busy_ign_r0", 3'd0, 8'h3C);
        sb_push("busy_ign_cout", 16'd0); sb_pop({15'd0, carry_out});
        step();
        sb_push("busy_ign_idle", 16'd0); sb_pop({15'd0, busy});

        // Reset during HI of an INC
        run_op("pre_rst", OP_INC, 3'd4, 3'd0, 2);
        sb_push("pre_rst_cout", 16'd1);  sb_pop({15'd0, carry_out});
        wr(3'd2, 8'hFF);
        op_code  = OP_INC;
        op_dst   = 3'd2;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_push("mid_rst_busy", 16'd0);  sb_pop({15'd0, busy});
        sb_push("mid_rst_done", 16'd0);  sb_pop({15'd0, done});
        sb_push("mid_rst_cout", 16'd0);  sb_pop({15'd0, carry_out});
        for (int i = 0; i < 8; i++) begin
            expect_reg($sformatf("mid_rst_r%0d", i), 3'(i), 8'h00);
        end
        step();
        sb_push("post_rst_done", 16'd0); sb_pop({15'd0, done});

        if (exp_q.size() != 0) begin
            check("sb_leftover", 16'(exp_q.size()), 16'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
